// File: rtl/data_memory_pkg.sv
// Shared encodings and helpers for the sized data memory.
package data_memory_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    DUMP_IDLE    = 2'b00,
    DUMP_READ    = 2'b01,
    DUMP_PRESENT = 2'b10,
    DUMP_DONE    = 2'b11
  } dump_state_t;

  localparam int NB_BYTE = 8;

  // Number of byte lanes in a data word of the given width.
  function automatic int lane_count(input int nb_data);
    lane_count = nb_data / NB_BYTE;
  endfunction

  // Alignment rule: byte always, half on even addresses, word on multiples of 4.
  function automatic logic access_legal(input size_t size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: access_legal = 1'b1;
      SIZE_HALF: access_legal = ~lane[0];
      SIZE_WORD: access_legal = (lane == 2'b00);
      default:   access_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_bram.sv
// Word-wide single-port RAM with per-byte write enables and a registered,
// read-before-write output. The array is not reset; it starts zeroed.
module data_memory_bram
  import data_memory_pkg::*;
#(
  parameter int NB_DATA  = 32,
  parameter int DEPTH    = 256,
  parameter int NB_WADDR = 8,
  localparam int NB_LANES = lane_count(NB_DATA)
) (
  input  logic                clock,
  input  logic                re,
  input  logic [NB_LANES-1:0] we,
  input  logic [NB_WADDR-1:0] addr,
  input  logic [NB_DATA-1:0]  wdata,
  output logic [NB_DATA-1:0]  rdata
);

  logic [NB_DATA-1:0] mem [DEPTH] = '{default: '0};

  // Byte-lane writes and registered read; the read sees the pre-write word.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NB_LANES; i++) begin
      if (we[i]) mem[addr][i*NB_BYTE +: NB_BYTE] <= wdata[i*NB_BYTE +: NB_BYTE];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_memory_sized.sv
// MEM-stage data memory: byte/half/word CPU access with extension and
// misalignment flagging, plus a handshaked full-memory dump for the debugger.
module data_memory_sized
  import data_memory_pkg::*;
#(
  parameter int NB_DATA      = 32,
  parameter int NB_ADDR      = 10,
  parameter int MEMORY_DEPTH = 256,
  localparam int NB_WADDR    = $clog2(MEMORY_DEPTH),
  localparam int NB_LANES    = lane_count(NB_DATA)
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_enable,
  input  logic                i_mem_write,
  input  logic                i_mem_read,
  input  logic [1:0]          i_size,
  input  logic                i_unsigned,
  input  logic [NB_ADDR-1:0]  i_address,
  input  logic [NB_DATA-1:0]  i_write_data,
  output logic [NB_DATA-1:0]  o_read_data,
  output logic                o_misaligned,
  input  logic                i_dump_start,
  input  logic                i_dump_ready,
  output logic                o_dump_valid,
  output logic [NB_DATA-1:0]  o_dump_data,
  output logic [NB_WADDR-1:0] o_dump_addr,
  output logic                o_dump_busy,
  output logic                o_dump_done
);

  // state        | meaning
  // DUMP_IDLE    | CPU owns the RAM, waiting for i_dump_start
  // DUMP_READ    | RAM read of word[count] in flight
  // DUMP_PRESENT | word presented, waiting for i_dump_ready
  // DUMP_DONE    | last word accepted, one-cycle done pulse

  dump_state_t         state_q, state_d;
  logic [NB_WADDR-1:0] count_q;
  logic                busy, last_word;

  size_t               size;
  logic [1:0]          lane;
  logic [NB_WADDR-1:0] cpu_waddr;
  logic                legal, cpu_access, cpu_store, cpu_load;
  logic [NB_LANES-1:0] cpu_be;
  logic [NB_DATA-1:0]  cpu_wdata;

  logic                ram_re;
  logic [NB_LANES-1:0] ram_we;
  logic [NB_WADDR-1:0] ram_addr;
  logic [NB_DATA-1:0]  ram_rdata;

  logic                rd_zero, rd_unsigned, misaligned_q;
  logic [1:0]          rd_lane;
  size_t               rd_size;
  logic [7:0]          sel_byte;
  logic [15:0]         sel_half;
  logic [NB_DATA-1:0]  load_ext;

  assign busy      = (state_q != DUMP_IDLE);
  assign last_word = (count_q == NB_WADDR'(MEMORY_DEPTH - 1));

  assign size       = size_t'(i_size);
  assign lane       = i_address[1:0];
  assign cpu_waddr  = i_address[NB_WADDR+1:2];
  assign legal      = access_legal(size, lane);
  assign cpu_access = i_enable & (i_mem_read | i_mem_write) & ~busy;
  assign cpu_store  = i_enable & i_mem_write & legal & ~busy;
  assign cpu_load   = i_enable & i_mem_read & legal & ~busy;

  // Steer right-aligned store data onto the addressed byte lanes.
  always_comb begin
    cpu_be    = '0;
    cpu_wdata = '0;
    case (size)
      SIZE_BYTE: begin
        cpu_be[lane] = 1'b1;
        cpu_wdata    = {NB_LANES{i_write_data[7:0]}};
      end
      SIZE_HALF: begin
        cpu_be[{lane[1], 1'b0}] = 1'b1;
        cpu_be[{lane[1], 1'b1}] = 1'b1;
        cpu_wdata               = {(NB_LANES/2){i_write_data[15:0]}};
      end
      SIZE_WORD: begin
        cpu_be    = '1;
        cpu_wdata = i_write_data;
      end
      default: begin
        cpu_be    = '0;
        cpu_wdata = '0;
      end
    endcase
  end

  // The dump FSM owns the RAM whenever it is busy; the CPU is halted then.
  assign ram_addr = busy ? count_q : cpu_waddr;
  assign ram_we   = cpu_store ? cpu_be : '0;
  assign ram_re   = busy ? (state_q == DUMP_READ) : cpu_load;

  data_memory_bram #(
    .NB_DATA  (NB_DATA),
    .DEPTH    (MEMORY_DEPTH),
    .NB_WADDR (NB_WADDR)
  ) u_bram (
    .clock (i_clock),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (cpu_wdata),
    .rdata (ram_rdata)
  );

  // Capture load shape alongside the RAM read so extraction lines up with it.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_zero      <= 1'b1;
      rd_unsigned  <= 1'b0;
      rd_lane      <= 2'b00;
      rd_size      <= SIZE_BYTE;
      misaligned_q <= 1'b0;
    end else if (busy) begin
      rd_zero      <= 1'b1;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= cpu_access & ~legal;
      if (i_enable) begin
        rd_zero <= ~cpu_load;
        if (cpu_load) begin
          rd_unsigned <= i_unsigned;
          rd_lane     <= lane;
          rd_size     <= size;
        end
      end
    end
  end

  // Pick the addressed byte/half from the registered word and extend it.
  always_comb begin
    sel_byte = 8'h00;
    case (rd_lane)
      2'd0: sel_byte = ram_rdata[7:0];
      2'd1: sel_byte = ram_rdata[15:8];
      2'd2: sel_byte = ram_rdata[23:16];
      2'd3: sel_byte = ram_rdata[31:24];
      default: sel_byte = 8'h00;
    endcase
    sel_half = rd_lane[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (rd_size)
      SIZE_BYTE: load_ext = {{(NB_DATA-8){~rd_unsigned & sel_byte[7]}}, sel_byte};
      SIZE_HALF: load_ext = {{(NB_DATA-16){~rd_unsigned & sel_half[15]}}, sel_half};
      default:   load_ext = ram_rdata;
    endcase
  end

  assign o_read_data  = (rd_zero | busy) ? '0 : load_ext;
  assign o_misaligned = misaligned_q;

  // Dump FSM state register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= DUMP_IDLE;
    else            state_q <= state_d;
  end

  // Dump FSM next state and handshake outputs.
  always_comb begin
    state_d      = state_q;
    o_dump_valid = 1'b0;
    o_dump_done  = 1'b0;
    case (state_q)
      DUMP_IDLE:    if (i_dump_start) state_d = DUMP_READ;
      DUMP_READ:    state_d = DUMP_PRESENT;
      DUMP_PRESENT: begin
        o_dump_valid = 1'b1;
        if (i_dump_ready) state_d = last_word ? DUMP_DONE : DUMP_READ;
      end
      DUMP_DONE: begin
        o_dump_done = 1'b1;
        state_d     = DUMP_IDLE;
      end
      default: state_d = DUMP_IDLE;
    endcase
  end

  // Word counter: cleared on start, advanced on each non-final handshake.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else if (state_q == DUMP_IDLE && i_dump_start) begin
      count_q <= '0;
    end else if (state_q == DUMP_PRESENT && i_dump_ready && !last_word) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign o_dump_data = (state_q == DUMP_PRESENT) ? ram_rdata : '0;
  assign o_dump_addr = count_q;
  assign o_dump_busy = busy;

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
- Parametrised successor to the pipeline's word-only data memory, placed in the MEM stage.
- Byte-addressed CPU port with byte, halfword and word loads and stores, sign or zero extension, and misalignment detection.
- Adds a debug dump port: an FSM streams every word out to the debug unit with a valid/ready handshake while the CPU is halted.

Parameters:
NB_DATA, 32, data word width (multiple of 16).
NB_ADDR, 10, CPU byte-address width.
MEMORY_DEPTH, 256, number of words; must be at most 2**(NB_ADDR-2).
NB_WADDR, $clog2(MEMORY_DEPTH), word-index width (derived, local).

Ports:
i_clock  in  1  clock; all state updates on the rising edge
i_reset_n  in  1  asynchronous, active-low reset
i_enable  in  1  CPU port enable
i_mem_write  in  1  store strobe
i_mem_read  in  1  load strobe
i_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved
i_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend loads
i_address  in  NB_ADDR  byte address
i_write_data  in  NB_DATA  store data, right-aligned
o_read_data  out  NB_DATA  load result, extended
o_misaligned  out  1  one-cycle flag for an illegal access
i_dump_start  in  1  start full-memory dump
i_dump_ready  in  1  debug unit accepts the current word
o_dump_valid  out  1  o_dump_data/o_dump_addr valid
o_dump_data  out  NB_DATA  dumped word
o_dump_addr  out  NB_WADDR  word index of o_dump_data
o_dump_busy  out  1  dump FSM not IDLE
o_dump_done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (async, i_reset_n=0): all outputs 0; FSM to IDLE; counter 0.
  - The memory array is NOT cleared by reset; it is zero-initialised at time 0.
- Word index = i_address[NB_WADDR+1:2]; lane = i_address[1:0].
- Legality:
  - byte: always legal.
  - half: illegal if addr[0]=1.
  - word: illegal if addr[1:0]!=0.
  - size 11: always illegal.
- Illegal access with i_enable=1 and (read or write): no array write. On the next cycle, o_read_data=0 and o_misaligned=1 for exactly one cycle.
- Store (i_enable & i_mem_write & legal) writes only the addressed lanes via byte enables:
  - SB: data[7:0] to lane.
  - SH: data[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - SW: all lanes.
- Load (i_enable & i_mem_read & legal), one-cycle latency:
  - The word plus registered lane/size/unsigned are captured at edge N.
  - o_read_data is extracted and extended from those registers, valid after edge N.
  - Byte/half sign-extend from bit 7/15 unless i_unsigned=1.
- i_enable=1 with i_mem_read=0: o_read_data goes to 0 next cycle.
- i_enable=0: o_read_data holds; no write.
- Read and write of the same word in the same cycle: the write commits, and the read returns the OLD word (read-before-write).
- Dump FSM states:
  - IDLE: i_dump_start=1 -> READ, counter=0.
  - READ: array read of word[counter] -> PRESENT.
  - PRESENT: o_dump_valid=1, data/addr stable.
    - Stays in PRESENT while i_dump_ready=0.
    - Handshake with counter==MEMORY_DEPTH-1 -> DONE.
    - Handshake otherwise -> counter+1, READ.
  - DONE: o_dump_done=1 for one cycle -> IDLE.
- i_dump_start outside IDLE is ignored.
- o_dump_busy=1 in every state except IDLE.
- While o_dump_busy=1 the CPU port is ignored: no writes, o_read_data forced to 0, o_misaligned=0. The debug unit guarantees the CPU is halted.
- Reset mid-dump: immediate return to IDLE; o_dump_valid=0; no o_dump_done.
- Throughput: one word per 2 cycles with i_dump_ready tied high.

Decomposition:
- Package data_memory_pkg:
  - size encodings (SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10);
  - dump FSM state encodings;
  - lane-count constant NB_DATA/8.
- Sub-module data_memory_bram: word-wide single-port RAM with per-byte write enables and a registered read, shared by the CPU and dump paths through a mux selected by o_dump_busy.
- Lane steering, extension, legality checks and the dump FSM live in the top module.

Test Plan:
- SW 0xAABBCC01 @0x10, then LW @0x10 -> o_read_data=0xAABBCC01 one cycle after the load; o_misaligned=0.
- SB 0x85 @0x13 over 0: LB @0x13 -> 0xFFFFFF85; LBU @0x13 -> 0x00000085; LW @0x10 -> 0x85000000.
- SH 0x1234 @0x21 -> o_misaligned pulses 1 cycle, word @0x20 unchanged; LW @0x22 -> o_misaligned=1, o_read_data=0; size=11 -> flagged.
- Same cycle SW 0x11111111 and LW @0x30 (old value 0x0) -> read returns 0x0; next LW returns 0x11111111.
- MEMORY_DEPTH=4 preloaded with 1,2,3,4; dump with i_dump_ready toggling 0/1:
  - exactly 4 handshakes, addr 0..3, data 1..4;
  - data stable while ready=0;
  - o_dump_done pulses once;
  - a CPU SW during the dump leaves memory unchanged.
- Assert i_reset_n=0 while in PRESENT at addr 2 -> o_dump_valid, o_dump_busy, o_read_data=0 immediately; memory contents retained; a new dump restarts at addr 0.
